// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch stage: widths, NOP encoding,
// instruction field positions and opcode values.
package fetch_pkg;

  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'hF000;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int DST_HI = 11;
  localparam int DST_LO = 8;
  localparam int OP1_HI = 7;
  localparam int OP1_LO = 4;
  localparam int OP2_HI = 3;
  localparam int OP2_LO = 0;

  // 4'hF is reserved as NOP and is never hazard-checked.
  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_NOP = 4'hF
  } opcode_e;

  function automatic logic is_hazard_op(input logic [3:0] opc);
    return opc[3:2] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry instruction/PC holding register.
// Ports: load (capture load_*), consume (drop), clear (flush); valid/instr/pc out.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               consume,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [PC_W-1:0]    load_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      pc_d    = load_pc;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// PC generation, sync imem drive, skid buffer and IF/ID register.
// Ports: clock/reset, imem_addr/imem_data, IF_ID_Hold, branch_taken/target,
// IF_ID_* outputs; stall_count only when FETCH_STALL_CNT_EN is defined.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               IF_ID_Hold,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [INSTR_W-1:0] IF_ID_instr,
  output logic [PC_W-1:0]    IF_ID_pc,
  output logic               IF_ID_valid,
  output logic [3:0]         IF_ID_opcode,
  output logic [3:0]         IF_ID_dest,
  output logic [3:0]         IF_ID_op1,
  output logic [3:0]         IF_ID_op2
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]        stall_count
`endif
);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic               req_valid_q, req_valid_d;
  logic [PC_W-1:0]    req_pc_q, req_pc_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;

  logic               skid_load, skid_consume, skid_clear;
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;

  fetch_skid_buf #(.PC_W(PC_W)) u_skid (
    .clock      (clock),
    .reset      (reset),
    .load       (skid_load),
    .consume    (skid_consume),
    .clear      (skid_clear),
    .load_instr (imem_data),
    .load_pc    (req_pc_q),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  always_comb begin
    pc_d         = pc_q;
    req_valid_d  = req_valid_q;
    req_pc_d     = req_pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    skid_load    = 1'b0;
    skid_consume = 1'b0;
    skid_clear   = 1'b0;
    if (branch_taken) begin
      pc_d         = branch_target;
      req_valid_d  = 1'b0;
      skid_clear   = 1'b1;
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
      ifid_pc_d    = '0;
    end else if (IF_ID_Hold) begin
      // Park the word returning this cycle; it would otherwise be lost.
      skid_load   = req_valid_q && !skid_valid;
      req_valid_d = 1'b0;
    end else begin
      pc_d        = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
      req_valid_d = 1'b1;
      req_pc_d    = pc_q;
      if (skid_valid) begin
        skid_consume = 1'b1;
        ifid_valid_d = 1'b1;
        ifid_instr_d = skid_instr;
        ifid_pc_d    = skid_pc;
      end else if (req_valid_q) begin
        ifid_valid_d = 1'b1;
        ifid_instr_d = imem_data;
        ifid_pc_d    = req_pc_q;
      end else begin
        ifid_valid_d = 1'b0;
        ifid_instr_d = NOP_INSTR;
        ifid_pc_d    = '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      req_valid_q  <= 1'b0;
      req_pc_q     <= '0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      req_valid_q  <= req_valid_d;
      req_pc_q     <= req_pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (IF_ID_Hold && !branch_taken && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count = stall_cnt_q;
`endif

  assign imem_addr    = pc_q;
  assign IF_ID_instr  = ifid_instr_q;
  assign IF_ID_pc     = ifid_pc_q;
  assign IF_ID_valid  = ifid_valid_q;
  assign IF_ID_opcode = ifid_instr_q[OPC_HI:OPC_LO];
  assign IF_ID_dest   = ifid_instr_q[DST_HI:DST_LO];
  assign IF_ID_op1    = ifid_instr_q[OP1_HI:OP1_LO];
  assign IF_ID_op2    = ifid_instr_q[OP2_HI:OP2_LO];

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected IF/ID loads are queued by the
// driver and popped by a negedge monitor.
module tb_fetch_stage;

  logic        clock;
  logic        reset;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        IF_ID_Hold;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [15:0] IF_ID_instr;
  logic [7:0]  IF_ID_pc;
  logic        IF_ID_valid;
  logic [3:0]  IF_ID_opcode, IF_ID_dest, IF_ID_op1, IF_ID_op2;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  fetch_stage #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clock         (clock),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .IF_ID_Hold    (IF_ID_Hold),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .IF_ID_instr   (IF_ID_instr),
    .IF_ID_pc      (IF_ID_pc),
    .IF_ID_valid   (IF_ID_valid),
    .IF_ID_opcode  (IF_ID_opcode),
    .IF_ID_dest    (IF_ID_dest),
    .IF_ID_op1     (IF_ID_op1),
    .IF_ID_op2     (IF_ID_op2)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_count   (stall_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [15:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
  always @(posedge clock) imem_data <= mem[imem_addr];

  typedef struct packed {
    logic        v;
    logic [7:0]  pc;
    logic [15:0] instr;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  localparam int K_NONE = 0;
  localparam int K_LOAD = 1;
  localparam int K_HOLD = 2;
  localparam int K_BR   = 3;
  int kind = K_NONE;

  always @(posedge clock or posedge reset) begin
    if (reset)             kind = K_NONE;
    else if (branch_taken) kind = K_BR;
    else if (IF_ID_Hold)   kind = K_HOLD;
    else                   kind = K_LOAD;
  end

  logic        p_v;
  logic [7:0]  p_pc;
  logic [15:0] p_in;

  always @(negedge clock) begin
    if (!reset) begin
      if (kind == K_LOAD) begin
        if (q.size() == 0) begin
          chk("sb_underflow", 32'd0, 32'd1);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("ld_valid", 32'(IF_ID_valid), 32'(e.v));
          chk("ld_instr", 32'(IF_ID_instr), 32'(e.instr));
          if (e.v) begin
            chk("ld_pc", 32'(IF_ID_pc), 32'(e.pc));
            chk("ld_opcode", 32'(IF_ID_opcode), 32'(e.instr[15:12]));
            chk("ld_op2", 32'(IF_ID_op2), 32'(e.instr[3:0]));
          end
        end
      end else if (kind == K_BR) begin
        chk("br_valid", 32'(IF_ID_valid), 32'd0);
        chk("br_instr", 32'(IF_ID_instr), 32'hF000);
      end else if (kind == K_HOLD) begin
        chk("hold_pc", 32'(IF_ID_pc), 32'(p_pc));
        chk("hold_valid", 32'(IF_ID_valid), 32'(p_v));
        chk("hold_instr", 32'(IF_ID_instr), 32'(p_in));
      end
      p_v  = IF_ID_valid;
      p_pc = IF_ID_pc;
      p_in = IF_ID_instr;
    end
  end

  task automatic push(input logic [7:0] pc);
    exp_t e;
    e.v     = 1'b1;
    e.pc    = pc;
    e.instr = 16'h1000 + {8'h00, pc};
    q.push_back(e);
  endtask

  task automatic bubble();
    exp_t e;
    e.v     = 1'b0;
    e.pc    = 8'h00;
    e.instr = 16'hF000;
    q.push_back(e);
  endtask

  task automatic cyc(input logic h, input logic b, input logic [7:0] t);
    IF_ID_Hold    = h;
    branch_taken  = b;
    branch_target = t;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_valid", 32'(IF_ID_valid), 32'd0);
    chk("rst_instr", 32'(IF_ID_instr), 32'hF000);
    chk("rst_pc", 32'(IF_ID_pc), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
`ifdef FETCH_STALL_CNT_EN
    chk("rst_stall_cnt", 32'(stall_count), 32'd0);
`endif
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    IF_ID_Hold = 1'b0;
    branch_taken = 1'b0;
    branch_target = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    chk_reset_vals();
    reset = 1'b0;

    bubble(); cyc(0, 0, 0);
    for (int p = 0; p < 5; p++) begin
      push(8'(p)); cyc(0, 0, 0);
    end
    repeat (3) cyc(1, 0, 0);
    push(8'h05); cyc(0, 0, 0);
    push(8'h06); cyc(0, 0, 0);
    push(8'h07); cyc(0, 0, 0);

    cyc(0, 1, 8'h40);
    chk("redir_addr_40", 32'(imem_addr), 32'h40);
    bubble();    cyc(0, 0, 0);
    push(8'h40); cyc(0, 0, 0);
    push(8'h41); cyc(0, 0, 0);

    cyc(1, 0, 0);
    cyc(1, 1, 8'h80);
    chk("redir_addr_80", 32'(imem_addr), 32'h80);
    bubble();    cyc(0, 0, 0);
    push(8'h80); cyc(0, 0, 0);
    push(8'h81); cyc(0, 0, 0);

    cyc(0, 1, 8'hFE);
    bubble();    cyc(0, 0, 0);
    push(8'hFE); cyc(0, 0, 0);
    chk("wrap_addr", 32'(imem_addr), 32'h00);
    push(8'hFF); cyc(0, 0, 0);
    push(8'h00); cyc(0, 0, 0);
    push(8'h01); cyc(0, 0, 0);

    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 8'h20);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    bubble();    cyc(0, 0, 0);
    push(8'h20); cyc(0, 0, 0);
    push(8'h21); cyc(0, 0, 0);
`ifdef FETCH_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_count), 32'd8);
`endif

    cyc(1, 0, 0);
    #1;
    reset = 1'b1;
    #1;
    chk_reset_vals();
    IF_ID_Hold = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    bubble();    cyc(0, 0, 0);
    push(8'h00); cyc(0, 0, 0);
    push(8'h01); cyc(0, 0, 0);
    #10;
    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
